// File: rtl/operand_packer.sv
`default_nettype none
// ============================================================================
// Module   : operand_packer
// Function : packs BUS_W-bit chunks into NUM_OPS operands of OP_W bits, then
//            holds the frame until the consumer takes it.
// Revision : 1.0
// ============================================================================
module operand_packer #(
   parameter int BUS_W     = 8,
   parameter int OP_W      = 16,
   parameter int NUM_OPS   = 2,
   parameter int MSB_FIRST = 0,
   localparam int K        = OP_W / BUS_W,
   localparam int T        = K * NUM_OPS,
   localparam int IW       = (T > 1) ? $clog2(T) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      abort,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BUS_W-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_OPS*OP_W-1:0]   out_data,
   output logic [IW-1:0]             chunk_idx
);

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [NUM_OPS*OP_W-1:0]   data_q, data_d;
   logic                      accept;

   if ((OP_W % BUS_W) != 0 || NUM_OPS < 1) begin : g_param_check
      $error("operand_packer: OP_W must be a multiple of BUS_W and NUM_OPS >= 1");
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (idx_q == IW'(T - 1)) begin
                  idx_d   = '0;
                  state_d = S_HOLD;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
      // abort wins over any accept or handshake in the same cycle
      if (abort) begin
         state_d = S_COLLECT;
         idx_d   = '0;
         accept  = 1'b0;
      end
   end

   // One slot per chunk index; each slot only ever touches its own slice.
   for (genvar c = 0; c < T; c++) begin : g_slot
      localparam int SL  = (MSB_FIRST != 0) ? (K - 1 - (c % K)) : (c % K);
      localparam int OFS = (c / K) * OP_W + SL * BUS_W;
      assign data_d[OFS +: BUS_W] = abort ? '0 :
                                    (accept && idx_q == IW'(c)) ? in_data :
                                    data_q[OFS +: BUS_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_COLLECT;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   assign out_data  = data_q;
   assign chunk_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_packer
// Function : drives three packer configurations from shared inputs and checks
//            them against a behavioural frame model.
// Revision : 1.0
// ============================================================================
module tb_operand_packer;

   logic        clk = 1'b0;
   logic        rst, abort, in_valid, out_ready;
   logic [7:0]  in_data;

   logic        def_ir, def_ov, msb_ir, msb_ov, one_ir, one_ov;
   logic [31:0] def_od, msb_od;
   logic [7:0]  one_od;
   logic [1:0]  def_ci, msb_ci;
   logic [0:0]  one_ci;

   int checks = 0;
   int errors = 0;

   // model: instance 0 = defaults, 1 = MSB_FIRST, 2 = single 8-bit operand
   bit [63:0] m_data[3];
   int        m_idx[3];
   bit        m_hold[3];
   int        mk[3]   = '{2, 2, 1};
   int        mt[3]   = '{4, 4, 1};
   int        mmsb[3] = '{0, 1, 0};
   int        mopw[3] = '{16, 16, 8};

   operand_packer #(.BUS_W(8), .OP_W(16), .NUM_OPS(2), .MSB_FIRST(0)) u_def (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(def_ir),
      .in_data(in_data), .out_valid(def_ov), .out_ready(out_ready),
      .out_data(def_od), .chunk_idx(def_ci));

   operand_packer #(.BUS_W(8), .OP_W(16), .NUM_OPS(2), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(msb_ir),
      .in_data(in_data), .out_valid(msb_ov), .out_ready(out_ready),
      .out_data(msb_od), .chunk_idx(msb_ci));

   operand_packer #(.BUS_W(8), .OP_W(8), .NUM_OPS(1), .MSB_FIRST(0)) u_one (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(one_ir),
      .in_data(in_data), .out_valid(one_ov), .out_ready(out_ready),
      .out_data(one_od), .chunk_idx(one_ci));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_data[i] = '0;
         m_idx[i]  = 0;
         m_hold[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (abort) begin
            m_data[i] = '0;
            m_idx[i]  = 0;
            m_hold[i] = 1'b0;
         end else if (!m_hold[i]) begin
            if (in_valid) begin
               int op, s, sh;
               op = m_idx[i] / mk[i];
               s  = m_idx[i] % mk[i];
               if (mmsb[i] != 0) s = mk[i] - 1 - s;
               sh = op * mopw[i] + s * 8;
               m_data[i] = (m_data[i] & ~(64'hFF << sh)) | (64'(in_data) << sh);
               m_idx[i]++;
               if (m_idx[i] == mt[i]) begin
                  m_idx[i]  = 0;
                  m_hold[i] = 1'b1;
               end
            end
         end else if (out_ready) begin
            m_hold[i] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] od[3];
      logic [63:0] ci[3];
      logic        ov[3];
      logic        ir[3];
      od[0] = 64'(def_od); od[1] = 64'(msb_od); od[2] = 64'(one_od);
      ci[0] = 64'(def_ci); ci[1] = 64'(msb_ci); ci[2] = 64'(one_ci);
      ov[0] = def_ov; ov[1] = msb_ov; ov[2] = one_ov;
      ir[0] = def_ir; ir[1] = msb_ir; ir[2] = one_ir;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(m_hold[i]));
         chk($sformatf("in_ready[%0d]", i),  64'(ir[i]), 64'(!m_hold[i]));
         chk($sformatf("out_data[%0d]", i),  od[i], m_data[i]);
         chk($sformatf("chunk_idx[%0d]", i), ci[i], 64'(m_idx[i]));
      end
   endtask

   task automatic step(input bit a, input bit v, input logic [7:0] d, input bit r);
      abort     = a;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // basic frame, both chunk orders
      step(0, 1, 8'h34, 0);
      step(0, 1, 8'h12, 0);
      step(0, 1, 8'h78, 0);
      step(0, 1, 8'h56, 0);
      chk("frame_lsb_first", 64'(def_od), 64'h56781234);
      chk("frame_msb_first", 64'(msb_od), 64'h78563412);
      chk("in_ready_in_hold", 64'(def_ir), 64'h0);

      // hold with stalled consumer and toggling in_valid
      for (int n = 0; n < 5; n++) step(0, n[0], 8'($urandom), 0);
      chk("hold_stable", 64'(def_od), 64'h56781234);
      step(0, 0, 8'h00, 1);
      chk("released_valid", 64'(def_ov), 64'h0);
      chk("released_ready", 64'(def_ir), 64'h1);

      // abort mid-frame with a chunk present
      step(0, 1, 8'hA1, 0);
      step(0, 1, 8'hA2, 0);
      step(1, 1, 8'hFF, 0);
      chk("abort_idx", 64'(def_ci), 64'h0);
      chk("abort_data", 64'(def_od), 64'h0);
      chk("abort_valid", 64'(def_ov), 64'h0);
      step(0, 1, 8'h01, 0);
      step(0, 1, 8'h02, 0);
      step(0, 1, 8'h03, 0);
      step(0, 1, 8'h04, 0);
      chk("frame_after_abort", 64'(def_od), 64'h04030201);
      step(0, 0, 8'h00, 1);

      // asynchronous reset mid-frame
      step(0, 1, 8'($urandom), 0);
      step(0, 1, 8'($urandom), 0);
      chk("midframe_idx", 64'(def_ci), 64'h2);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      chk("rst_mid_idx", 64'(def_ci), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // asynchronous reset in HOLD
      for (int n = 0; n < 4; n++) step(0, 1, 8'($urandom), 0);
      chk("hold_before_rst", 64'(def_ov), 64'h1);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      chk("rst_hold_valid", 64'(def_ov), 64'h0);
      chk("rst_hold_data", 64'(def_od), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single-chunk frames with consumer always ready
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'hAA, 1);
      chk("t1_frame_aa", 64'(one_od), 64'hAA);
      chk("t1_valid_aa", 64'(one_ov), 64'h1);
      chk("t1_ready_aa", 64'(one_ir), 64'h0);
      step(0, 1, 8'hBB, 1);
      chk("t1_gap_valid", 64'(one_ov), 64'h0);
      chk("t1_gap_ready", 64'(one_ir), 64'h1);
      step(0, 1, 8'hBB, 1);
      chk("t1_frame_bb", 64'(one_od), 64'hBB);
      chk("t1_valid_bb", 64'(one_ov), 64'h1);
      chk("t1_idx", 64'(one_ci), 64'h0);
      step(0, 0, 8'h00, 1);
      chk("t1_done_valid", 64'(one_ov), 64'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 16) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 2) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 The block SHALL have parameter BUS_W, default 8, meaning input chunk width in bits.
REQ-002 The block SHALL have parameter OP_W, default 16, meaning operand width in bits; must be an integer multiple of BUS_W.
REQ-003 The block SHALL have parameter NUM_OPS, default 2, meaning number of operands packed per frame; must be at least 1.
REQ-004 The block SHALL have parameter MSB_FIRST, default 0: 0 means the first chunk of each operand is its least-significant slice; 1 means the first chunk is its most-significant slice.
REQ-005 Derived: K = OP_W/BUS_W chunks per operand; T = K*NUM_OPS chunks per frame; IW = max(1, clog2(T)).
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 abort  input  1  synchronous frame discard.
REQ-009 in_valid  input  1  in_data holds a chunk.
REQ-010 in_ready  output  1  block accepts a chunk this cycle.
REQ-011 in_data  input  BUS_W  chunk data.
REQ-012 out_valid  output  1  out_data holds a complete frame.
REQ-013 out_ready  input  1  consumer takes the frame.
REQ-014 out_data  output  NUM_OPS*OP_W  operand j occupies bits [j*OP_W +: OP_W].
REQ-015 chunk_idx  output  IW  index of the next chunk slot within the frame.

Function
REQ-016 The block SHALL implement a two-state machine: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1), with both outputs decoded from state only.
REQ-017 In COLLECT, a chunk is accepted on a rising edge where in_valid=1; with in_valid=0 nothing changes.
REQ-018 An accepted chunk at index c SHALL be written to operand c/K at slice s = c%K when MSB_FIRST=0, or at slice s = K-1-c%K when MSB_FIRST=1, where slice s occupies bits [s*BUS_W +: BUS_W] of that operand.
REQ-019 The write SHALL modify only the addressed slice; all other out_data bits hold their value.
REQ-020 On acceptance with c<T-1, chunk_idx SHALL increment by 1.
REQ-021 On acceptance with c=T-1, chunk_idx SHALL wrap to 0 and the state SHALL move to HOLD, so out_valid=1 in the cycle after the last accept (latency 1).
REQ-022 In HOLD, out_data and chunk_idx SHALL be stable, and in_valid SHALL be ignored.
REQ-023 In HOLD, a rising edge with out_ready=1 completes the transfer and returns the state to COLLECT; out_data keeps its value until overwritten slice by slice.
REQ-024 out_ready in COLLECT SHALL have no effect.
REQ-025 When T=1, every accepted chunk SHALL go directly to HOLD, and chunk_idx SHALL stay 0.
REQ-026 abort=1 SHALL take priority over all other inputs: next state COLLECT, chunk_idx=0, out_data cleared to 0, and any chunk or handshake in the same cycle discarded.
REQ-027 All arithmetic on chunk_idx SHALL be unsigned IW-bit, and no value above T-1 is ever reached.
REQ-028 Illegal parameter combinations (OP_W not a multiple of BUS_W, or NUM_OPS<1) SHALL be rejected at elaboration.

Reset
REQ-029 While rst=1, asynchronously: state=COLLECT, chunk_idx=0, out_data=0; hence in_ready=1 and out_valid=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or completed frame with no output handshake.
REQ-031 After rst deasserts, the first rising edge with in_valid=1 SHALL accept the chunk into index 0.

Verification
REQ-032 Defaults: chunks 0x34, 0x12, 0x78, 0x56 on consecutive cycles -> out_valid=1 one cycle after the 4th accept, out_data=0x56781234, in_ready=0 while out_valid=1.
REQ-033 MSB_FIRST=1, same chunks -> out_data=0x78563412.
REQ-034 In HOLD, out_ready held 0 for 5 cycles while in_valid toggles -> out_data unchanged and no chunk consumed; then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle.
REQ-035 Send 2 chunks, then abort=1 with in_valid=1 in the same cycle -> chunk_idx=0, out_data=0, out_valid stays 0; the next 4 chunks form a clean frame.
REQ-036 Assert rst in HOLD and in mid-frame (chunk_idx=2) -> out_valid=0, chunk_idx=0 and out_data=0 immediately, without waiting for a clock edge.
REQ-037 BUS_W=8, OP_W=8, NUM_OPS=1 with back-to-back chunks 0xAA, 0xBB and out_ready=1 -> frames 0xAA then 0xBB, with one cycle of out_valid per frame and in_ready alternating 1/0.
